// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : FETCH issues/holds the current PC request; DISCARD waits for a
//                   stale request to complete after a redirect arrived mid-miss.
//   INSTR_W       : instruction / address width.
//   DEFAULT_NOP   : default bubble instruction.
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_NOP = 32'h0000_0000;

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_pc_next_sel.sv
// pc_next_sel: combinational next-PC mux for the fetch stage.
// Ports:
//   in_discard    : FSM is in DISCARD (stale request outstanding)
//   pc            : current PC
//   redir_pc      : saved redirect target
//   pc_write      : 1 = PC may advance on a hit
//   imem_ready    : memory completes the request this cycle
//   branch_taken / branch_target, jump / jump_target : redirect sources
//   redirect      : a redirect is requested this cycle
//   target        : word-aligned redirect target (branch has priority)
//   next_pc       : PC value for the next cycle
module pc_next_sel
  import if_fetch_unit_pkg::*;
(
  input  logic               in_discard,
  input  logic [INSTR_W-1:0] pc,
  input  logic [INSTR_W-1:0] redir_pc,
  input  logic               pc_write,
  input  logic               imem_ready,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  input  logic               jump,
  input  logic [INSTR_W-1:0] jump_target,
  output logic               redirect,
  output logic [INSTR_W-1:0] target,
  output logic [INSTR_W-1:0] next_pc
);

  logic [INSTR_W-1:0] raw_target;

  always_comb begin
    redirect   = branch_taken | jump;
    raw_target = branch_taken ? branch_target : jump_target;
    target     = raw_target & ~32'h0000_0003;

    // PC only moves when the outstanding request completes; the address must
    // stay stable for the whole request.
    next_pc = pc;
    if (imem_ready) begin
      if (redirect)
        next_pc = target;
      else if (in_discard)
        next_pc = redir_pc;
      else if (pc_write)
        next_pc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Owns the PC, drives the I-memory request
// handshake and presents the fetched instruction and its PC+4 to IF/ID.
// Ports:
//   CLK, RESET                      : clock (rising edge), async active-high reset
//   PCWrite                         : 1 = PC may advance, 0 = hazard hold
//   Branch_Taken/Branch_Target      : branch redirect (priority over jump)
//   Jump/Jump_Target                : jump redirect
//   IMEM_Req/IMEM_Addr              : fetch request and word-aligned address
//   IMEM_Ready/IMEM_Data            : request completion and returned instruction
//   IF_Instruction/IF_PC_4          : instruction and PC+4 to IF/ID
//   Fetch_Stall                     : no valid instruction this cycle
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PCWrite,
  input  logic               Branch_Taken,
  input  logic [INSTR_W-1:0] Branch_Target,
  input  logic               Jump,
  input  logic [INSTR_W-1:0] Jump_Target,
  output logic               IMEM_Req,
  output logic [INSTR_W-1:0] IMEM_Addr,
  input  logic               IMEM_Ready,
  input  logic [INSTR_W-1:0] IMEM_Data,
  output logic [INSTR_W-1:0] IF_Instruction,
  output logic [INSTR_W-1:0] IF_PC_4,
  output logic               Fetch_Stall
);

  fetch_state_e       state;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] redir_pc;
  logic               redirect;
  logic [INSTR_W-1:0] target;
  logic [INSTR_W-1:0] next_pc;
  logic               hit;

  pc_next_sel u_pc_next_sel (
    .in_discard    (state == S_DISCARD),
    .pc            (pc),
    .redir_pc      (redir_pc),
    .pc_write      (PCWrite),
    .imem_ready    (IMEM_Ready),
    .branch_taken  (Branch_Taken),
    .branch_target (Branch_Target),
    .jump          (Jump),
    .jump_target   (Jump_Target),
    .redirect      (redirect),
    .target        (target),
    .next_pc       (next_pc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      redir_pc <= '0;
    end else begin
      pc <= next_pc;
      case (state)
        S_FETCH: begin
          // A redirect during a miss cannot change the address mid-request;
          // remember it and drop the data of the stale request.
          if (!IMEM_Ready && redirect) begin
            redir_pc <= target;
            state    <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (redirect)
            redir_pc <= target;
          if (IMEM_Ready)
            state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    hit            = !RESET && (state == S_FETCH) && IMEM_Ready;
    IMEM_Req       = !RESET;
    IMEM_Addr      = pc;
    IF_Instruction = hit ? IMEM_Data : NOP_INSTR;
    IF_PC_4        = RESET ? '0 : pc + 32'd4;
    Fetch_Stall    = !hit;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PCWrite;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ready;
  logic [31:0] IMEM_Data;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC_4;
  logic        Fetch_Stall;

  if_fetch_unit #(
    .RESET_PC  (T_RESET_PC),
    .NOP_INSTR (T_NOP)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .PCWrite        (PCWrite),
    .Branch_Taken   (Branch_Taken),
    .Branch_Target  (Branch_Target),
    .Jump           (Jump),
    .Jump_Target    (Jump_Target),
    .IMEM_Req       (IMEM_Req),
    .IMEM_Addr      (IMEM_Addr),
    .IMEM_Ready     (IMEM_Ready),
    .IMEM_Data      (IMEM_Data),
    .IF_Instruction (IF_Instruction),
    .IF_PC_4        (IF_PC_4),
    .Fetch_Stall    (Fetch_Stall)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        in_reset;
    logic        check_pc4;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        stall;
    logic        req;
  } exp_t;

  exp_t sb[$];
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model: current fetch address, plus "a redirect is pending and the
  // in-flight data must be thrown away" with the address to go to afterwards.
  logic [31:0] m_pc;
  bit          m_pending;
  logic [31:0] m_dest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fetch-stage result, pop its expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("req", {31'd0, IMEM_Req}, {31'd0, e.req});
        chk("stall", {31'd0, Fetch_Stall}, {31'd0, e.stall});
        chk("instr", IF_Instruction, e.instr);
        if (e.check_pc4) chk("pc4", IF_PC_4, e.pc4);
        if (!e.in_reset) chk("addr", IMEM_Addr, e.addr);
      end
    end
  end

  // One clock of stimulus: drive inputs, push the expected response, advance model.
  task automatic cycle(input bit rst, input bit pcw, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit rdy,
                       input logic [31:0] data);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    @(posedge CLK);
    #1;
    RESET = rst; PCWrite = pcw; Branch_Taken = br; Branch_Target = bt;
    Jump = j; Jump_Target = jt; IMEM_Ready = rdy; IMEM_Data = data;

    redir = br || j;
    tgt   = br ? bt : jt;
    tgt   = {tgt[31:2], 2'b00};

    if (rst) begin
      e = '{in_reset: 1'b1, check_pc4: 1'b1, addr: 32'h0, instr: T_NOP,
            pc4: 32'h0, stall: 1'b1, req: 1'b0};
      m_pc = T_RESET_PC; m_pending = 0; m_dest = 32'h0;
    end else begin
      e.in_reset  = 1'b0;
      e.req       = 1'b1;
      e.addr      = m_pc;
      e.pc4       = m_pc + 32'd4;
      e.check_pc4 = !m_pending;
      if (!m_pending && rdy) begin
        e.instr = data; e.stall = 1'b0;
      end else begin
        e.instr = T_NOP; e.stall = 1'b1;
      end
      if (m_pending) begin
        if (redir) m_dest = tgt;
        if (rdy) begin m_pc = m_dest; m_pending = 0; end
      end else if (rdy) begin
        if (redir) m_pc = tgt;
        else if (pcw) m_pc = m_pc + 32'd4;
      end else if (redir) begin
        m_pending = 1; m_dest = tgt;
      end
    end
    sb.push_back(e);
  endtask

  task automatic hit(input bit pcw);
    cycle(0, pcw, 0, 32'h0, 0, 32'h0, 1, $urandom);
  endtask

  initial begin
    RESET = 1'b1; PCWrite = 0; Branch_Taken = 0; Branch_Target = '0;
    Jump = 0; Jump_Target = '0; IMEM_Ready = 0; IMEM_Data = '0;
    m_pc = T_RESET_PC; m_pending = 0; m_dest = '0;

    // Reset state, then zero-wait stream 0,4,8 with a 2-cycle hazard hold at 8.
    cycle(1, 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    cycle(1, 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    hit(1); hit(1);
    hit(0); hit(0);
    hit(1); hit(1);                               // 8 -> C -> 10
    // Miss at 0x10 for 3 cycles, then hit -> 0x14.
    repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 32'h1111_1111);
    cycle(0, 1, 0, 0, 0, 0, 1, 32'hABCD_0010);
    hit(1); hit(1); hit(1);                       // 14,18,1C -> 20
    // Jump to 0x100 during a miss at 0x20; stale data dropped.
    cycle(0, 1, 0, 0, 1, 32'h0000_0100, 0, 32'h2020_2020);
    cycle(0, 1, 0, 0, 0, 0, 0, 32'h2020_2020);
    cycle(0, 1, 0, 0, 0, 0, 1, 32'h2020_2020);
    // Miss at 0x100, jump to 0x300 then redirect to 0x200 while waiting.
    cycle(0, 1, 0, 0, 1, 32'h0000_0300, 0, 32'h0);
    cycle(0, 1, 1, 32'h0000_0202, 0, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 0, 1, 32'h3333_3333);
    // Branch and jump together with PCWrite=0: branch wins.
    cycle(0, 0, 1, 32'h0000_0040, 1, 32'h0000_0080, 1, 32'h4444_4444);
    hit(1);
    // PC wraps from 0xFFFF_FFFC.
    cycle(0, 1, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h5555_5555);
    hit(1); hit(1);
    // Reset asserted mid-miss.
    cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
    cycle(1, 1, 0, 0, 0, 0, 0, 32'h0);
    hit(1); hit(1);

    // Randomized traffic with occasional misses, redirects, holds and resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 2) != 0), $urandom);
    end

    @(posedge CLK);
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge CLK);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
